ext_obi_mem_responder: RTL and testbench

OBI responder (slave end) for the external crossbar slave port of the CGRA/X-HEEP system. The crossbar drives it with `obi_req_t`; it answers with `obi_resp_t` from a private word-addressed scratchpad with configurable read latency. It is the counterpart of the CGRA's OBI master ports: those initiate transactions, this block terminates them. It provides a local buffer that CPU and DMA can reach through the external xbar slave port.

---
 rtl/ext_obi_mem_pkg.sv | 19 +
 rtl/obi_pkg.sv | 23 ++
 rtl/ext_obi_mem_resp_pipe.sv | 43 ++++
 rtl/ext_obi_mem_responder.sv | 92 +++++++++
 tb/tb_ext_obi_mem_responder.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ext_obi_mem_pkg.sv
// ext_obi_mem_pkg: shared constants and response-stage type for the external OBI scratchpad.
// Revision 1.0
`default_nettype none

package ext_obi_mem_pkg;

    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 4;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBADCAB1E;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
    } resp_stage_t;

endpackage

`default_nettype wire

// File: rtl/obi_pkg.sv
// obi_pkg: OBI 1.x request/response bundles shared by crossbar masters and responders.
// Revision 1.0
`default_nettype none

package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

`default_nettype wire

// File: rtl/ext_obi_mem_resp_pipe.sv
// ext_obi_mem_resp_pipe: LATENCY-deep response shift register with synchronous clear.
// Revision 1.0
`default_nettype none

module ext_obi_mem_resp_pipe
    import ext_obi_mem_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  resp_stage_t stage_in,
    output resp_stage_t stage_out,
    output logic        busy
);

    resp_stage_t stages [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= stage_in;
            for (int i = 1; i < int'(LATENCY); i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < int'(LATENCY); i++) begin
            busy = busy | stages[i].valid;
        end
    end

    assign stage_out = stages[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/ext_obi_mem_responder.sv
// ext_obi_mem_responder: OBI responder backed by a word-addressed scratchpad, fixed read latency.
// Revision 1.0
`default_nettype none

module ext_obi_mem_responder
    import ext_obi_mem_pkg::*;
    import obi_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 1024,
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter logic [31:0] ERR_DATA  = ERR_DATA_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  obi_req_t    slave_req_i,
    output obi_resp_t   slave_resp_o,
    output logic        busy_o,
    output logic [15:0] err_count_o
);

    localparam int unsigned WORD_AW   = $clog2(NUM_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(NUM_WORDS) << 2;

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("ext_obi_mem_responder: LATENCY out of range");
    end
    if ((NUM_WORDS & (NUM_WORDS - 1)) != 0) begin : g_bad_depth
        $error("ext_obi_mem_responder: NUM_WORDS must be a power of two");
    end

    logic               handshake;
    logic               in_range;
    logic [31:0]        offset;
    logic [WORD_AW-1:0] word;
    logic [15:0]        err_count;
    resp_stage_t        stage_in;
    resp_stage_t        stage_out;

    // Behavioural array; contents are intentionally not reset.
    logic [31:0] mem [NUM_WORDS];

    // Unsigned subtraction makes addresses below BASE_ADDR wrap out of range.
    assign handshake = slave_req_i.req & ~rst_i;
    assign offset    = slave_req_i.addr - BASE_ADDR;
    assign in_range  = (offset < MEM_BYTES);
    assign word      = offset[WORD_AW+1:2];

    always_ff @(posedge clk_i) begin
        if (handshake && slave_req_i.we && in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (slave_req_i.be[k]) begin
                    mem[word][8*k +: 8] <= slave_req_i.wdata[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        stage_in.valid = handshake;
        stage_in.rdata = 32'h0;
        if (handshake && !slave_req_i.we) begin
            stage_in.rdata = in_range ? mem[word] : ERR_DATA;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_count <= 16'h0;
        end else if (handshake && !in_range && err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
        end
    end

    ext_obi_mem_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clk       (clk_i),
        .rst       (rst_i),
        .stage_in  (stage_in),
        .stage_out (stage_out),
        .busy      (busy_o)
    );

    assign slave_resp_o.gnt    = handshake;
    assign slave_resp_o.rvalid = stage_out.valid;
    assign slave_resp_o.rdata  = stage_out.rdata;
    assign err_count_o         = err_count;

endmodule

`default_nettype wire

// File: tb/tb_ext_obi_mem_responder.sv
// tb_ext_obi_mem_responder: randomized and directed bench with a transaction-level response model.
// Revision 1.0
`default_nettype none

module tb_ext_obi_mem_responder;
    import obi_pkg::*;

    localparam int          LAT   = 3;
    localparam int          WORDS = 16;
    localparam logic [31:0] BASE  = 32'h100;
    localparam logic [31:0] ERRD  = 32'hBADCAB1E;

    logic        clk;
    logic        rst;
    obi_req_t    req_s;
    obi_resp_t   resp;
    logic        busy;
    logic [15:0] err_count;

    int checks;
    int failures;

    ext_obi_mem_responder #(
        .NUM_WORDS (WORDS),
        .LATENCY   (LAT),
        .BASE_ADDR (BASE),
        .ERR_DATA  (ERRD)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .slave_req_i  (req_s),
        .slave_resp_o (resp),
        .busy_o       (busy),
        .err_count_o  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mm [WORDS];
    logic [15:0] m_err;
    int          cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: every accepted request yields one response LAT cycles later.
    always @(posedge clk) begin
        logic [31:0] off;
        logic [31:0] d;
        bit          inr;
        int          w;
        if (rst) begin
            q.delete();
            m_err = 16'h0;
        end else if (req_s.req) begin
            off = req_s.addr - BASE;
            inr = (off < WORDS * 4);
            w   = int'(off / 4) % WORDS;
            d   = 32'h0;
            if (req_s.we) begin
                if (inr)
                    for (int k = 0; k < 4; k++)
                        if (req_s.be[k]) mm[w][8*k +: 8] = req_s.wdata[8*k +: 8];
            end else begin
                d = inr ? mm[w] : ERRD;
            end
            if (!inr && m_err != 16'hFFFF) m_err = m_err + 16'd1;
            q.push_back('{due: cyc + LAT, data: d});
        end
        cyc++;
    end

    always @(negedge clk) begin
        chk("busy", {31'h0, busy}, {31'h0, q.size() != 0});
        chk("gnt", {31'h0, resp.gnt}, {31'h0, req_s.req && !rst});
        chk("err_count", {16'h0, err_count}, {16'h0, m_err});
        if (q.size() != 0 && q[0].due == cyc) begin
            chk("rvalid", {31'h0, resp.rvalid}, 32'h1);
            chk("rdata", resp.rdata, q[0].data);
            void'(q.pop_front());
        end else begin
            chk("rvalid_idle", {31'h0, resp.rvalid}, 32'h0);
            chk("rdata_idle", resp.rdata, 32'h0);
        end
    end

    task automatic set_in(input bit r, input bit w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] d);
        req_s.req   = r;
        req_s.we    = w;
        req_s.be    = b;
        req_s.addr  = a;
        req_s.wdata = d;
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        int nrv;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        m_err    = 16'h0;
        rst      = 1'b1;
        // A write presented while in reset must not land.
        set_in(1'b1, 1'b1, 4'hF, BASE, 32'hFFFFFFFF);
        repeat (3) begin
            @(negedge clk);
            chk("rst_rvalid", {31'h0, resp.rvalid}, 32'h0);
            chk("rst_rdata", resp.rdata, 32'h0);
            chk("rst_busy", {31'h0, busy}, 32'h0);
            chk("rst_err", {16'h0, err_count}, 32'h0);
            chk("rst_gnt", {31'h0, resp.gnt}, 32'h0);
            to_next();
        end
        rst = 1'b0;

        for (int i = 0; i < WORDS; i++) begin
            set_in(1'b1, 1'b1, 4'hF, BASE + 32'(i * 4), 32'(i));
            to_next();
        end
        idle();
        repeat (LAT + 1) to_next();

        // Eight back-to-back reads: data 0..7 from handshake+LAT, busy throughout.
        for (int i = 0; i < 8 + LAT; i++) begin
            if (i < 8) set_in(1'b1, 1'b0, 4'hF, BASE + 32'(i * 4), 32'h0);
            else idle();
            @(negedge clk);
            if (i >= 1) chk("b2b_busy", {31'h0, busy}, 32'h1);
            if (i >= LAT) begin
                chk("b2b_rvalid", {31'h0, resp.rvalid}, 32'h1);
                chk("b2b_rdata", resp.rdata, 32'(i - LAT));
            end
            to_next();
        end
        idle();
        repeat (LAT + 1) to_next();

        // Out-of-range read above the window.
        set_in(1'b1, 1'b0, 4'hF, 32'h140, 32'h0);
        to_next();
        idle();
        @(negedge clk);
        chk("oor_rd_count", {16'h0, err_count}, 32'h1);
        to_next();
        to_next();
        @(negedge clk);
        chk("oor_rd_rvalid", {31'h0, resp.rvalid}, 32'h1);
        chk("oor_rd_data", resp.rdata, 32'hBADCAB1E);
        to_next();
        // Write just below BASE wraps out of range and is dropped.
        set_in(1'b1, 1'b1, 4'hF, 32'h0FC, 32'h12345678);
        to_next();
        idle();
        @(negedge clk);
        chk("oor_wr_count", {16'h0, err_count}, 32'h2);
        to_next();
        set_in(1'b1, 1'b0, 4'hF, 32'h13C, 32'h0);
        to_next();
        idle();
        to_next();
        to_next();
        @(negedge clk);
        chk("last_word_data", resp.rdata, 32'd15);
        to_next();
        repeat (LAT) to_next();

        // Write then read-after-write of the same word.
        set_in(1'b1, 1'b1, 4'hF, 32'h110, 32'hDEADBEEF);
        to_next();
        set_in(1'b1, 1'b0, 4'hF, 32'h110, 32'h0);
        to_next();
        idle();
        to_next();
        @(negedge clk);
        chk("wr_resp_rvalid", {31'h0, resp.rvalid}, 32'h1);
        chk("wr_resp_rdata", resp.rdata, 32'h0);
        to_next();
        @(negedge clk);
        chk("raw_rdata", resp.rdata, 32'hDEADBEEF);
        to_next();
        repeat (LAT) to_next();

        // Byte-lane merge.
        set_in(1'b1, 1'b1, 4'hF, 32'h120, 32'h11223344);
        to_next();
        set_in(1'b1, 1'b1, 4'b0101, 32'h120, 32'hAABBCCDD);
        to_next();
        set_in(1'b1, 1'b0, 4'hF, 32'h120, 32'h0);
        to_next();
        idle();
        to_next();
        to_next();
        @(negedge clk);
        chk("be_merge", resp.rdata, 32'h11BB33DD);
        to_next();
        repeat (LAT) to_next();

        // Reset mid-flight discards two reads; a write during reset is dropped.
        nrv = 0;
        set_in(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        to_next();
        set_in(1'b1, 1'b0, 4'hF, 32'h104, 32'h0);
        to_next();
        rst = 1'b1;
        set_in(1'b1, 1'b1, 4'hF, 32'h100, 32'hFFFFFFFF);
        @(negedge clk);
        chk("midrst_gnt", {31'h0, resp.gnt}, 32'h0);
        to_next();
        rst = 1'b0;
        idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp.rvalid) nrv++;
            to_next();
        end
        chk("midrst_no_rvalid", 32'(nrv), 32'h0);
        set_in(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        to_next();
        idle();
        to_next();
        to_next();
        @(negedge clk);
        chk("post_rst_rvalid", {31'h0, resp.rvalid}, 32'h1);
        chk("post_rst_rdata", resp.rdata, 32'h0);
        to_next();
        repeat (LAT) to_next();

        // Saturate the error counter.
        set_in(1'b1, 1'b0, 4'hF, 32'h140, 32'h0);
        repeat (70000) to_next();
        idle();
        @(negedge clk);
        chk("err_saturated", {16'h0, err_count}, 32'h0000FFFF);
        to_next();
        repeat (LAT) to_next();

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            int          sel;
            sel = int'($urandom_range(0, 7));
            if (sel < 6)       a = BASE + 32'($urandom_range(0, WORDS - 1) * 4) + 32'($urandom_range(0, 3));
            else if (sel == 6) a = 32'h140 + 32'($urandom_range(0, 63) * 4);
            else               a = $urandom;
            rst = ($urandom_range(0, 63) == 0);
            set_in($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), a, $urandom);
            to_next();
        end
        rst = 1'b0;
        idle();
        repeat (LAT + 2) to_next();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
